// File: rtl/voice_rr_arbiter.sv
// ============================================================================
// voice_rr_arbiter
// ----------------------------------------------------------------------------
// Registered arbiter that hands the shared sample generator in note_to_sample
// to one of N note voices at a time. It replaces the older combinational
// fixed-priority arbiter. Once a voice owns the generator it keeps it until
// the generator pulses done, the voice drops its request, or (optionally) a
// hold timeout forces a release. Round-robin fairness is the default, and
// fixed priority (lowest index wins) remains available through RR_MODE=0.
//
// Parameters:
//   N         number of requesting voices (>= 2)
//   RR_MODE   1 = round-robin, 0 = fixed priority (lowest index wins)
//   MAX_HOLD  longest a single grant may be held, in cycles (>= 2); only
//             meaningful when ARB_TIMEOUT_EN is defined
//
// Optional feature macro:
//   ARB_TIMEOUT_EN  when defined, a hold counter forces a release after
//                   MAX_HOLD cycles and pulses o_timeout for one cycle.
//                   When undefined, grants are held indefinitely and
//                   o_timeout is tied low.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_reset_n      synchronous active-low reset
//   i_req[N]       level requests, bit i = voice i wants the generator
//   i_done         one-cycle pulse from the generator: the owner is finished
//   o_grant[N]     registered one-hot grant, all zero when idle
//   o_grant_idx    binary index of the owner, 0 when idle
//   o_grant_valid  high while any grant is held
//   o_timeout      one-cycle pulse following a forced release
// ============================================================================
module voice_rr_arbiter #(
    parameter int N        = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_done,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_grant_valid,
    output logic                 o_timeout
);

    localparam int IW = $clog2(N);

    // Catch illegal parameter combinations at elaboration rather than
    // letting them produce a silently broken arbiter.
    if (N < 2 || MAX_HOLD < 2) begin : g_paramCheck
        $error("voice_rr_arbiter: N and MAX_HOLD must both be >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [N-1:0]    r_grant;
    logic [N-1:0]    w_nextGrant;
    logic [IW-1:0]   r_grantIdx;
    logic [IW-1:0]   w_nextIdx;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_nextPtr;
    logic [IW-1:0]   w_winIdx;
    logic            w_anyReq;
    logic            w_withdraw;
    logic            w_forced;
    logic            w_release;
    logic            w_newGrant;

    // Picks the winning voice. In round-robin mode the scan starts at the
    // pointer and wraps, so the voice just after the last owner is favoured;
    // in fixed mode the scan always starts at index 0. The result is only
    // used when at least one request is present.
    function automatic logic [IW-1:0] pickWinner(input logic [N-1:0] req,
                                                 input logic [IW-1:0] ptr);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (RR_MODE != 0) ? ((int'(ptr) + i) % N) : i;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        return win;
    endfunction

    assign w_anyReq   = |i_req;
    assign w_winIdx   = pickWinner(i_req, r_ptr);
    // The owner withdrawing is a release just like done; both in the same
    // cycle still count as a single release.
    assign w_withdraw = ~i_req[r_grantIdx];
    assign w_release  = (r_state == BUSY) && (i_done || w_withdraw || w_forced);
    // A new grant is loaded from idle on any request, or on a release when
    // someone (possibly the old owner, if it wins again) is still asking.
    assign w_newGrant = w_anyReq && ((r_state == IDLE) || w_release);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);

    logic [CW-1:0] r_holdCnt;
    logic          r_timeout;

    // A forced release only happens when nothing else is releasing the
    // owner this cycle, so timeout never pulses on an ordinary handover.
    assign w_forced = (r_state == BUSY) && (r_holdCnt == CW'(MAX_HOLD - 1))
                      && !i_done && !w_withdraw;

    // Hold counter: restarts on every grant (including a re-grant to the
    // same voice) and counts each cycle the grant stays put. The timeout
    // flag is simply the forced-release decision delayed by one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_holdCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_forced;
            if (w_newGrant || (w_nextState == IDLE)) begin
                r_holdCnt <= '0;
            end else if (r_state == BUSY) begin
                r_holdCnt <= r_holdCnt + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_forced  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Next-state logic. In BUSY nothing changes unless a release occurs;
    // a release either hands straight over to the next winner with no idle
    // bubble, or returns to IDLE with all outputs cleared. The pointer moves
    // one past each new owner so that owner becomes lowest priority next time.
    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        w_nextIdx   = r_grantIdx;
        w_nextPtr   = r_ptr;

        if (w_newGrant) begin
            w_nextState           = BUSY;
            w_nextGrant           = '0;
            w_nextGrant[w_winIdx] = 1'b1;
            w_nextIdx             = w_winIdx;
            if (RR_MODE != 0) begin
                w_nextPtr = (w_winIdx == IW'(N - 1)) ? '0 : (w_winIdx + 1'b1);
            end
        end else if (w_release) begin
            w_nextState = IDLE;
            w_nextGrant = '0;
            w_nextIdx   = '0;
        end
    end

    // State and output registers. Reset drops any held grant immediately,
    // without waiting for done, and restarts the scan at voice 0.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_grantIdx <= w_nextIdx;
            r_ptr      <= w_nextPtr;
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_idx   = r_grantIdx;
    assign o_grant_valid = (r_state == BUSY);

endmodule

// File: tb/tb_voice_rr_arbiter.sv
// ============================================================================
// tb_voice_rr_arbiter
// ----------------------------------------------------------------------------
// Drives a round-robin and a fixed-priority voice_rr_arbiter side by side
// from the same request/done/reset stimulus and compares both against a
// behavioural model that tracks the owner as a plain integer (-1 = idle).
// Honors ARB_TIMEOUT_EN the same way the design does.
// ============================================================================
module tb_voice_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic         clk;
    logic         resetN;
    logic [N-1:0] req;
    logic         done;

    logic [N-1:0] grantRr, grantFix;
    logic [2:0]   idxRr, idxFix;
    logic         validRr, validFix;
    logic         tmoRr, tmoFix;

    int checkCount = 0;
    int errorCount = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority.
    int   owner [2];
    int   ptr   [2];
    int   hold  [2];
    logic tmoExp[2];

    voice_rr_arbiter #(.N(N), .RR_MODE(1), .MAX_HOLD(MAX_HOLD)) dutRr (
        .i_clk        (clk),
        .i_reset_n    (resetN),
        .i_req        (req),
        .i_done       (done),
        .o_grant      (grantRr),
        .o_grant_idx  (idxRr),
        .o_grant_valid(validRr),
        .o_timeout    (tmoRr)
    );

    voice_rr_arbiter #(.N(N), .RR_MODE(0), .MAX_HOLD(MAX_HOLD)) dutFix (
        .i_clk        (clk),
        .i_reset_n    (resetN),
        .i_req        (req),
        .i_done       (done),
        .o_grant      (grantFix),
        .o_grant_idx  (idxFix),
        .o_grant_valid(validFix),
        .o_timeout    (tmoFix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit reqBit(input logic [N-1:0] r, input int i);
        return ((r >> i) & 1) != 0;
    endfunction

    // Winner by the arbitration rules: scan from ptr with wrap in RR,
    // from 0 in fixed mode. Returns -1 when nobody is requesting.
    function automatic int pick(input int m, input logic [N-1:0] r);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m == 0) ? (ptr[m] + k) % N : k;
            if (reqBit(r, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic modelGrant(input int m);
        int w;
        w = pick(m, req);
        if (w < 0) begin
            owner[m] = -1;
        end else begin
            owner[m] = w;
            if (m == 0) ptr[m] = (w + 1) % N;
        end
        hold[m] = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic modelStep(input int m);
        bit rel, forced;
        if (!resetN) begin
            owner[m] = -1; ptr[m] = 0; hold[m] = 0; tmoExp[m] = 1'b0;
            return;
        end
        tmoExp[m] = 1'b0;
        if (owner[m] < 0) begin
            if (req != '0) modelGrant(m);
        end else begin
            rel    = done || !reqBit(req, owner[m]);
            forced = TIMEOUT_EN && !rel && (hold[m] == MAX_HOLD - 1);
            if (rel || forced) begin
                tmoExp[m] = forced;
                modelGrant(m);
            end else begin
                hold[m]++;
            end
        end
    endtask

    task automatic checkModel();
        logic [N-1:0] expGrant;
        int           expIdx;
        for (int m = 0; m < 2; m++) begin
            expGrant = (owner[m] < 0) ? '0 : (N'(1) << owner[m]);
            expIdx   = (owner[m] < 0) ? 0 : owner[m];
            if (m == 0) begin
                checkOutput("rr_grant", grantRr, expGrant);
                checkOutput("rr_idx", idxRr, expIdx);
                checkOutput("rr_valid", validRr, owner[m] >= 0);
                checkOutput("rr_timeout", tmoRr, tmoExp[m]);
            end else begin
                checkOutput("fix_grant", grantFix, expGrant);
                checkOutput("fix_idx", idxFix, expIdx);
                checkOutput("fix_valid", validFix, owner[m] >= 0);
                checkOutput("fix_timeout", tmoFix, tmoExp[m]);
            end
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, sample outputs 1 time unit later.
    task automatic applyStimulus(input logic rn, input logic [N-1:0] r, input logic d);
        @(negedge clk);
        resetN = rn;
        req    = r;
        done   = d;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkModel();
    endtask

    initial begin
        resetN = 1'b0;
        req    = '0;
        done   = 1'b0;
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; ptr[m] = 0; hold[m] = 0; tmoExp[m] = 1'b0;
        end

        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("reset_grant", grantRr, 8'h00);
        checkOutput("reset_valid", validRr, 1'b0);

        // Round-robin rotation with wrap.
        applyStimulus(1'b1, 8'b10001001, 1'b0);
        checkOutput("t1_grant0", grantRr, 8'b00000001);
        applyStimulus(1'b1, 8'b10001001, 1'b1);
        checkOutput("t1_grant3", grantRr, 8'b00001000);
        checkOutput("t1_idx3", idxRr, 3);
        applyStimulus(1'b1, 8'b10001001, 1'b1);
        checkOutput("t1_grant7", grantRr, 8'b10000000);
        checkOutput("t1_idx7", idxRr, 7);
        applyStimulus(1'b1, 8'b10001001, 1'b1);
        checkOutput("t1_wrap", grantRr, 8'b00000001);
        checkOutput("t1_fixed", grantFix, 8'b00000001);

        // Fixed mode re-grant and withdrawal.
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'b01001000, 1'b0);
        applyStimulus(1'b1, 8'b01001000, 1'b1);
        checkOutput("t2_regrant", grantFix, 8'b00001000);
        applyStimulus(1'b1, 8'b01000000, 1'b0);
        checkOutput("t2_withdraw", grantFix, 8'b01000000);

        // No preemption, pointer skip, release to idle.
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'b00000001, 1'b0);
        applyStimulus(1'b1, 8'b00101101, 1'b0);
        checkOutput("t3_hold", grantRr, 8'b00000001);
        applyStimulus(1'b1, 8'b00101101, 1'b1);
        checkOutput("t3_skip", grantRr, 8'b00000100);
        applyStimulus(1'b1, 8'b00000000, 1'b0);
        checkOutput("t3_idle", validRr, 1'b0);

        // Reset mid-grant, then pointer back at 0.
        applyStimulus(1'b1, 8'b00001000, 1'b0);
        applyStimulus(1'b0, 8'b00001000, 1'b0);
        checkOutput("t4_drop", grantRr, 8'h00);
        applyStimulus(1'b1, 8'b10000000, 1'b0);
        checkOutput("t4_regrant", grantRr, 8'b10000000);

        // Held requests without done: timeout rotation or indefinite hold.
        applyStimulus(1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'b00000011, 1'b0);
`ifdef ARB_TIMEOUT_EN
            if (i == 4) begin
                checkOutput("t5_rotate", grantRr, 8'b00000010);
                checkOutput("t5_timeout", tmoRr, 1'b1);
            end
`endif
        end
`ifndef ARB_TIMEOUT_EN
        checkOutput("t6_hold", grantRr, 8'b00000001);
        checkOutput("t6_timeout", tmoRr, 1'b0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            r = req;
            if ($urandom_range(3) == 0) r = N'($urandom);
            applyStimulus(($urandom_range(63) != 0), r, ($urandom_range(3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
